// File: rtl/fetch_unit_if.sv
// Bus between the fetch stage and its environment: instruction memory port,
// decode-stage redirect requests and the IR/RAS status outputs.
interface fetch_unit_if #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16
);
  logic [PC_WIDTH-1:0]          pc;
  logic [INSTRUCTION_WIDTH-1:0] instruction;
  logic                         stall;
  logic                         branch_valid;
  logic                         call_valid;
  logic                         return_valid;
  logic [PC_WIDTH-1:0]          branch_target;
  logic [INSTRUCTION_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]          ir_pc;
  logic                         ir_valid;
  logic                         ras_overflow;
  logic                         ras_underflow;

  // The fetch unit itself is the master side.
  modport master (
    output pc, ir, ir_pc, ir_valid, ras_overflow, ras_underflow,
    input  instruction, stall, branch_valid, call_valid, return_valid, branch_target
  );

  modport slave (
    input  pc, ir, ir_pc, ir_valid, ras_overflow, ras_underflow,
    output instruction, stall, branch_valid, call_valid, return_valid, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// PucCPU instruction fetch stage: PC, instruction register, redirect handling
// and a circular return-address stack that overwrites its oldest entry when full.
module fetch_unit #(
  parameter int PC_WIDTH          = 8,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int RAS_DEPTH         = 4
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

  logic [PC_WIDTH-1:0]          pc_q, pc_d;
  logic [INSTRUCTION_WIDTH-1:0] ir_q;
  logic [PC_WIDTH-1:0]          irPc_q;
  logic                         irValid_q, irValid_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic                         overflow_q, overflow_d;
  logic                         underflow_q, underflow_d;
  logic [PC_WIDTH-1:0]          ras_q [RAS_DEPTH];

  logic                         accept;
  logic                         doReturn;
  logic                         doCall;
  logic                         doBranch;
  logic                         rasPush;
  logic [PC_WIDTH-1:0]          irPcPlusOne;
  logic [PTR_W-1:0]             ptrMinusOne;

  // ptr_q is the next free slot; the top of stack sits one below it.
  always_comb begin
    accept      = irValid_q & ~bus.stall;
    doReturn    = accept & bus.return_valid;
    doCall      = accept & bus.call_valid & ~bus.return_valid;
    doBranch    = accept & bus.branch_valid & ~bus.return_valid & ~bus.call_valid;
    irPcPlusOne = irPc_q + PC_WIDTH'(1);
    ptrMinusOne = ptr_q - PTR_W'(1);

    pc_d        = pc_q + PC_WIDTH'(1);
    ptr_d       = ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rasPush     = 1'b0;

    if (doReturn) begin
      if (count_q != '0) begin
        pc_d    = ras_q[ptrMinusOne];
        ptr_d   = ptrMinusOne;
        count_d = count_q - CNT_W'(1);
      end else begin
        pc_d        = irPcPlusOne;
        underflow_d = 1'b1;
      end
    end else if (doCall) begin
      rasPush = 1'b1;
      pc_d    = bus.branch_target;
      ptr_d   = ptr_q + PTR_W'(1);
      if (count_q == RAS_FULL) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (doBranch) begin
      pc_d = bus.branch_target;
    end

    // The word latched alongside an accepted redirect came from the wrong path.
    irValid_d = ~(doReturn | doCall | doBranch);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= '0;
      ir_q        <= '0;
      irPc_q      <= '0;
      irValid_q   <= 1'b0;
      ptr_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else if (!bus.stall) begin
      pc_q        <= pc_d;
      ir_q        <= bus.instruction;
      irPc_q      <= pc_q;
      irValid_q   <= irValid_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (rasPush) begin
        ras_q[ptr_q] <= irPcPlusOne;
      end
    end
  end

  assign bus.pc            = pc_q;
  assign bus.ir            = ir_q;
  assign bus.ir_pc         = irPc_q;
  assign bus.ir_valid      = irValid_q;
  assign bus.ras_overflow  = overflow_q;
  assign bus.ras_underflow = underflow_q;

endmodule
